occupancy_map_arbiter: RTL and testbench

//  Owns the single port of the occupancy-map RAM (256x128 cells) inside the occupancy module.

---
 rtl/occupancy_map_arbiter.sv | 121 ++++++++++++
 tb/tb_occupancy_map_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/occupancy_map_arbiter.sv
// Occupancy-map RAM port owner: clears the whole map after reset or on
// request, then shares the single RAM port between the map-update requester
// (read/write) and the scan-matcher requester (read-only) using round-robin.
module occupancy_map_arbiter #(
  parameter int                        ADDR_WIDTH = 15,
  parameter int                        DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  ready,
  input  logic                  upd_req,
  input  logic                  upd_we,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic [DATA_WIDTH-1:0] upd_wdata,
  output logic                  upd_gnt,
  output logic                  upd_rvalid,
  output logic [DATA_WIDTH-1:0] upd_rdata,
  input  logic                  mat_req,
  input  logic [ADDR_WIDTH-1:0] mat_addr,
  output logic                  mat_gnt,
  output logic                  mat_rvalid,
  output logic [DATA_WIDTH-1:0] mat_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  rr_q, rr_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  upd_rvalid_q, upd_rvalid_d;
  logic                  mat_rvalid_q, mat_rvalid_d;

  // Next-state, arbitration and RAM port mux; rr_q=0 means update wins a tie
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rr_d      = rr_q;
    upd_gnt   = 1'b0;
    mat_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = last_addr_q;
    mem_wdata = INIT_VALUE;
    case (state_q)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = count_q;
        count_d  = count_q + 1'b1;
        if (count_q == '1) state_d = SERVE;
      end
      SERVE: begin
        if (clear_start) begin
          state_d = CLEAR;
          count_d = '0;
        end else begin
          if (upd_req && (!mat_req || !rr_q)) upd_gnt = 1'b1;
          else if (mat_req)                   mat_gnt = 1'b1;
          if (upd_gnt) begin
            mem_addr  = upd_addr;
            mem_we    = upd_we;
            mem_wdata = upd_wdata;
            rr_d      = 1'b1;
          end
          if (mat_gnt) begin
            mem_addr = mat_addr;
            rr_d     = 1'b0;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
    last_addr_d  = mem_addr;
    ready_d      = (state_d == SERVE);
    busy_d       = (state_d == CLEAR);
    upd_rvalid_d = upd_gnt & ~upd_we;
    mat_rvalid_d = mat_gnt;
  end

  // State, sweep counter, round-robin pointer and registered status/rvalid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      count_q      <= '0;
      last_addr_q  <= '0;
      rr_q         <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
      upd_rvalid_q <= 1'b0;
      mat_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_addr_q  <= last_addr_d;
      rr_q         <= rr_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      upd_rvalid_q <= upd_rvalid_d;
      mat_rvalid_q <= mat_rvalid_d;
    end
  end

  // Read data is only presented to the owner of the returning read
  always_comb begin
    ready      = ready_q;
    clear_busy = busy_q;
    upd_rvalid = upd_rvalid_q;
    mat_rvalid = mat_rvalid_q;
    upd_rdata  = upd_rvalid_q ? mem_rdata : '0;
    mat_rdata  = mat_rvalid_q ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_occupancy_map_arbiter.sv
// Directed bench for occupancy_map_arbiter with a synchronous RAM model.
module tb_occupancy_map_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear_start = 1'b0;
  logic        clear_busy, ready;
  logic        upd_req = 1'b0, upd_we = 1'b0;
  logic [14:0] upd_addr = '0;
  logic [15:0] upd_wdata = '0;
  logic        upd_gnt, upd_rvalid;
  logic [15:0] upd_rdata;
  logic        mat_req = 1'b0;
  logic [14:0] mat_addr = '0;
  logic        mat_gnt, mat_rvalid;
  logic [15:0] mat_rdata;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] ram [0:32767];

  int compared = 0;
  int mismatched = 0;
  int bad;

  occupancy_map_arbiter dut (
    .clock(clock), .reset(reset), .clear_start(clear_start),
    .clear_busy(clear_busy), .ready(ready),
    .upd_req(upd_req), .upd_we(upd_we), .upd_addr(upd_addr),
    .upd_wdata(upd_wdata), .upd_gnt(upd_gnt), .upd_rvalid(upd_rvalid),
    .upd_rdata(upd_rdata),
    .mat_req(mat_req), .mat_addr(mat_addr), .mat_gnt(mat_gnt),
    .mat_rvalid(mat_rvalid), .mat_rdata(mat_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM, read-before-write
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // One full clear sweep: every cycle must write INIT_VALUE to the next address
  task automatic applyStimulus(input bit pulse_mid, output int sweep_bad);
    sweep_bad = 0;
    for (int i = 0; i < 32768; i++) begin
      clear_start = (pulse_mid && i == 500);
      #1;
      if (!(mem_we === 1'b1 && mem_addr === 15'(i) && mem_wdata === 16'h0 &&
            ready === 1'b0 && clear_busy === 1'b1 && upd_gnt === 1'b0 &&
            mat_gnt === 1'b0 && upd_rvalid === 1'b0 && mat_rvalid === 1'b0))
        sweep_bad++;
      nextCycle();
    end
    clear_start = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_busy", clear_busy, 1);
    checkOutput("rst_mem_we", mem_we, 1);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_rvalid", {upd_rvalid, mat_rvalid}, 0);

    // Reset in the middle of the first sweep
    for (int i = 0; i < 1000; i++) nextCycle();
    #1;
    checkOutput("sweep_addr_1000", mem_addr, 15'd1000);
    reset = 1'b1;
    #1;
    checkOutput("midrst_ready", ready, 0);
    checkOutput("midrst_busy", clear_busy, 1);
    checkOutput("midrst_mem_addr", mem_addr, 0);
    nextCycle();
    reset = 1'b0;

    // Full sweep with an ignored clear_start pulse at address 500
    $display("[TB] full clear sweep");
    applyStimulus(1'b1, bad);
    #1;
    checkOutput("sweep1_bad", bad, 0);
    checkOutput("sweep1_ready", ready, 1);
    checkOutput("sweep1_busy", clear_busy, 0);
    checkOutput("idle_gnt", {upd_gnt, mat_gnt}, 0);
    checkOutput("idle_mem_we", mem_we, 0);
    checkOutput("idle_hold_addr", mem_addr, 15'h7fff);

    // Update writes, then matcher read-back
    upd_req = 1'b1; upd_we = 1'b1; upd_addr = 15'h0200; upd_wdata = 16'hBEEF;
    #1;
    checkOutput("wr1_gnt", {upd_gnt, mat_gnt}, 2'b10);
    checkOutput("wr1_mem_we", mem_we, 1);
    checkOutput("wr1_mem_addr", mem_addr, 15'h0200);
    checkOutput("wr1_mem_wdata", mem_wdata, 16'hBEEF);
    nextCycle();
    upd_addr = 15'h0100; upd_wdata = 16'h1234;
    #1;
    checkOutput("wr2_gnt", upd_gnt, 1);
    checkOutput("wr2_mem_addr", mem_addr, 15'h0100);
    checkOutput("wr_no_rvalid", upd_rvalid, 0);
    nextCycle();
    upd_req = 1'b0; upd_we = 1'b0; mat_req = 1'b1; mat_addr = 15'h0100;
    #1;
    checkOutput("rd_gnt", {upd_gnt, mat_gnt}, 2'b01);
    checkOutput("rd_mem_we", mem_we, 0);
    checkOutput("rd_mem_addr", mem_addr, 15'h0100);
    checkOutput("rd_no_upd_rvalid", upd_rvalid, 0);
    nextCycle();
    mat_req = 1'b0;
    #1;
    checkOutput("rd_mat_rvalid", mat_rvalid, 1);
    checkOutput("rd_mat_rdata", mat_rdata, 16'h1234);
    checkOutput("rd_upd_rvalid", upd_rvalid, 0);
    checkOutput("hold_addr", mem_addr, 15'h0100);
    nextCycle();
    #1;
    checkOutput("rd_rvalid_drop", mat_rvalid, 0);
    checkOutput("rd_rdata_zero", mat_rdata, 0);

    // Both requesters held: grants alternate, data to the right owner
    upd_req = 1'b1; upd_addr = 15'h0100; mat_req = 1'b1; mat_addr = 15'h0200;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput($sformatf("rr_gnt_%0d", k), {upd_gnt, mat_gnt},
                  (k % 2 == 0) ? 2'b10 : 2'b01);
      checkOutput($sformatf("rr_addr_%0d", k), mem_addr,
                  (k % 2 == 0) ? 15'h0100 : 15'h0200);
      checkOutput($sformatf("rr_upd_rv_%0d", k), {upd_rvalid, upd_rdata},
                  (k % 2 == 1) ? {1'b1, 16'h1234} : 17'h0);
      checkOutput($sformatf("rr_mat_rv_%0d", k), {mat_rvalid, mat_rdata},
                  (k > 0 && k % 2 == 0) ? {1'b1, 16'hBEEF} : 17'h0);
      nextCycle();
    end

    // clear_start beats a pending matcher request
    upd_req = 1'b0; mat_addr = 15'h0100; clear_start = 1'b1;
    #1;
    checkOutput("clr_no_gnt", {upd_gnt, mat_gnt}, 0);
    checkOutput("clr_mem_we", mem_we, 0);
    checkOutput("last_rd_rvalid", {mat_rvalid, mat_rdata}, {1'b1, 16'hBEEF});
    nextCycle();
    $display("[TB] requested clear sweep");
    applyStimulus(1'b0, bad);
    #1;
    checkOutput("sweep2_bad", bad, 0);
    checkOutput("sweep2_ready", ready, 1);
    checkOutput("post_clr_gnt", {upd_gnt, mat_gnt}, 2'b01);
    checkOutput("post_clr_addr", mem_addr, 15'h0100);
    nextCycle();
    mat_req = 1'b0;
    #1;
    checkOutput("post_clr_rvalid", mat_rvalid, 1);
    checkOutput("post_clr_rdata", mat_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
